// File: rtl/ccc_pkg.sv
// ccc_pkg: state encoding and ratio normalisation shared by ccc_clk_en_gen and its channels
package ccc_pkg;

    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN, LOST} state_e;

    function automatic logic [31:0] norm_ratio(input logic [31:0] r);
        return (r == '0) ? 32'd1 : r;
    endfunction

endpackage

// File: rtl/ccc_div_chan.sv
// ccc_div_chan: one divide-by-N enable channel with a shadowed ratio swapped in only at a wrap (DUTY needs CCC_DUTY_OUT_EN)
module ccc_div_chan
    import ccc_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             restart,
    input  logic             load,
    input  logic [DIV_W-1:0] div_in,
`ifdef CCC_DUTY_OUT_EN
    output logic             duty,
`endif
    output logic             ce
);

    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, shd_q, shd_d;
    logic             pend_q, pend_d;

    // Wrap detect, counter advance, ratio swap at wrap or RUN entry, shadow capture
    always_comb begin
        ce     = run && (cnt_q == div_q - DIV_W'(1));
        cnt_d  = (run && !ce) ? cnt_q + DIV_W'(1) : '0;
        div_d  = (restart || (ce && pend_q)) ? shd_q : div_q;
        pend_d = load || (pend_q && !restart && !ce);
        shd_d  = load ? DIV_W'(norm_ratio(32'(div_in))) : shd_q;
    end

`ifdef CCC_DUTY_OUT_EN
    // High for the first ceil(div/2) counts of each period
    always_comb duty = run && ({1'b0, cnt_q} < (({1'b0, div_q} + (DIV_W+1)'(1)) >> 1));
`endif

    // Channel registers; both ratios come out of reset at 1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            div_q  <= DIV_W'(1);
            shd_q  <= DIV_W'(1);
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/ccc_clk_en_gen.sv
// ccc_clk_en_gen: lock-supervised N-channel clock-enable generator; define CCC_DUTY_OUT_EN to add the DUTY port
module ccc_clk_en_gen
    import ccc_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int LOCK_STABLE = 1024,
    parameter int LOSS_CNT_W  = 8
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    LOCK,
    input  logic [NUM_CH*DIV_W-1:0] DIV,
    input  logic                    DIV_LOAD,
    input  logic                    LOSS_CLR,
    output logic [NUM_CH-1:0]       CE,
    output logic                    READY,
    output logic                    LOCK_LOST,
`ifdef CCC_DUTY_OUT_EN
    output logic [NUM_CH-1:0]       DUTY,
`endif
    output logic [LOSS_CNT_W-1:0]   LOSS_CNT
);

    localparam int SW = $clog2(LOCK_STABLE);

    state_e                state_q, state_d;
    logic [SW-1:0]         stab_q, stab_d;
    logic                  lock_m_q, lock_m_d, lock_s_q, lock_s_d;
    logic                  lost_q, lost_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;
    logic                  run, restart;

    // Lock qualification FSM, synchroniser and lock-loss bookkeeping
    always_comb begin
        lock_m_d = LOCK;
        lock_s_d = lock_m_q;
        state_d  = state_q;
        stab_d   = '0;
        restart  = 1'b0;
        case (state_q)
            WAIT_LOCK: state_d = lock_s_q ? SETTLE : WAIT_LOCK;
            SETTLE: begin
                stab_d = stab_q + SW'(1);
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                end else if (stab_q == SW'(LOCK_STABLE - 1)) begin
                    state_d = RUN;
                    restart = 1'b1;
                end
            end
            RUN:     state_d = lock_s_q ? RUN : LOST;
            default: state_d = WAIT_LOCK;
        endcase
        lost_d = (state_q == LOST) || (lost_q && !LOSS_CLR);
        loss_d = (state_q == LOST)
               ? (LOSS_CLR ? LOSS_CNT_W'(1) : loss_q + LOSS_CNT_W'(!(&loss_q)))
               : (LOSS_CLR ? '0 : loss_q);
    end

    // Top-level registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= WAIT_LOCK;
            stab_q   <= '0;
            lock_m_q <= 1'b0;
            lock_s_q <= 1'b0;
            lost_q   <= 1'b0;
            loss_q   <= '0;
        end else begin
            state_q  <= state_d;
            stab_q   <= stab_d;
            lock_m_q <= lock_m_d;
            lock_s_q <= lock_s_d;
            lost_q   <= lost_d;
            loss_q   <= loss_d;
        end
    end

    assign run       = (state_q == RUN);
    assign READY     = run;
    assign LOCK_LOST = lost_q;
    assign LOSS_CNT  = loss_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ccc_div_chan #(.DIV_W(DIV_W)) u_chan (
            .clk     (CLK),
            .rst_n   (RST_N),
            .run     (run),
            .restart (restart),
            .load    (DIV_LOAD),
            .div_in  (DIV[i*DIV_W +: DIV_W]),
`ifdef CCC_DUTY_OUT_EN
            .duty    (DUTY[i]),
`endif
            .ce      (CE[i])
        );
    end

endmodule

// File: tb/tb_ccc_clk_en_gen.sv
// tb_ccc_clk_en_gen: randomized self-checking bench with an event-level reference model
module tb_ccc_clk_en_gen;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 16;
    localparam int LS     = 16;
    localparam int LW     = 8;

    logic                    CLK = 1'b0;
    logic                    RST_N = 1'b0;
    logic                    LOCK = 1'b0;
    logic [NUM_CH*DIV_W-1:0] DIV = '0;
    logic                    DIV_LOAD = 1'b0;
    logic                    LOSS_CLR = 1'b0;
    logic [NUM_CH-1:0]       CE;
    logic                    READY;
    logic                    LOCK_LOST;
    logic [LW-1:0]           LOSS_CNT;
`ifdef CCC_DUTY_OUT_EN
    logic [NUM_CH-1:0]       DUTY;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    ccc_clk_en_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_STABLE(LS), .LOSS_CNT_W(LW)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .LOCK      (LOCK),
        .DIV       (DIV),
        .DIV_LOAD  (DIV_LOAD),
        .LOSS_CLR  (LOSS_CLR),
        .CE        (CE),
        .READY     (READY),
        .LOCK_LOST (LOCK_LOST),
`ifdef CCC_DUTY_OUT_EN
        .DUTY      (DUTY),
`endif
        .LOSS_CNT  (LOSS_CNT)
    );

    // Reference model: lock run-length, RUN age and per-channel scheduled fire times
    bit m_lm, m_ls, m_ready, m_lost, m_lock_lost, m_s, m_nready, m_nlost;
    int m_h, m_loss, m_age;
    int m_shd[NUM_CH], m_r[NUM_CH], m_nf[NUM_CH];
    bit m_pend[NUM_CH];

    function automatic int norm(input int r);
        return (r == 0) ? 1 : r;
    endfunction

    always @(posedge CLK) begin
        if (!RST_N) begin
            m_lm = 0; m_ls = 0; m_h = 0; m_ready = 0; m_lost = 0;
            m_lock_lost = 0; m_loss = 0; m_age = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_shd[i] = 1; m_r[i] = 1; m_nf[i] = 0; m_pend[i] = 0;
            end
        end else begin
            m_s = m_ls;
            if (m_lost) begin
                m_lock_lost = 1;
                m_loss = LOSS_CLR ? 1 : (m_loss == 255 ? 255 : m_loss + 1);
            end else if (LOSS_CLR) begin
                m_lock_lost = 0;
                m_loss = 0;
            end
            m_h = (m_lost || !m_s) ? 0 : m_h + 1;
            m_nlost = m_ready && !m_s;
            m_nready = m_ready ? m_s : (!m_lost && m_h >= LS + 1);
            if (m_ready) begin
                for (int i = 0; i < NUM_CH; i++)
                    if (m_age == m_nf[i]) begin
                        if (m_pend[i]) begin m_r[i] = m_shd[i]; m_pend[i] = 0; end
                        m_nf[i] += m_r[i];
                    end
                m_age++;
            end else if (m_nready) begin
                m_age = 0;
                for (int i = 0; i < NUM_CH; i++) begin
                    m_r[i] = m_shd[i]; m_pend[i] = 0; m_nf[i] = m_r[i] - 1;
                end
            end
            if (DIV_LOAD)
                for (int i = 0; i < NUM_CH; i++) begin
                    m_shd[i] = norm(int'(DIV[i*DIV_W +: DIV_W]));
                    m_pend[i] = 1;
                end
            m_ls = m_lm;
            m_lm = LOCK;
            m_ready = m_nready;
            m_lost = m_nlost;
        end
    end

    function automatic logic [NUM_CH-1:0] exp_ce();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = m_ready && (m_age == m_nf[i]);
        return v;
    endfunction

`ifdef CCC_DUTY_OUT_EN
    function automatic logic [NUM_CH-1:0] exp_duty();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++)
            v[i] = m_ready && ((m_age - (m_nf[i] - m_r[i] + 1)) < (m_r[i] + 1) / 2);
        return v;
    endfunction
`endif

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        check("ready", READY, m_ready);
        check("ce", CE, exp_ce());
        check("lock_lost", LOCK_LOST, m_lock_lost);
        check("loss_cnt", LOSS_CNT, m_loss);
`ifdef CCC_DUTY_OUT_EN
        check("duty", DUTY, exp_duty());
`endif
    endtask

    initial begin
        int n;
        int fires[$];
        // Power-up and lock qualification latency
        repeat (3) tick();
        check("rst_ready", READY, 0);
        check("rst_ce", CE, 0);
        RST_N = 1'b1;
        LOCK = 1'b1;
        DIV = {16'd8, 16'd3, 16'd2, 16'd1};
        DIV_LOAD = 1'b1;
        n = 0;
        do begin tick(); DIV_LOAD = 1'b0; n++; end while (!READY && n < 100);
        check("pwrup_lat", n, 19);
        // Phase alignment
        check("run1_ce", CE, 4'b0001);
        repeat (23) tick();
        check("align24", CE, 4'b1111);
        // Glitch-free reload of ch3 from 8 to 5 mid-period
        repeat (3) tick();
        DIV = {16'd5, 16'd3, 16'd2, 16'd1};
        DIV_LOAD = 1'b1;
        tick();
        DIV_LOAD = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (CE[3]) fires.push_back(i);
        end
        check("reload_cnt", fires.size(), 4);
        if (fires.size() == 4) begin
            check("reload_first", fires[0], 4);
            check("reload_p1", fires[1] - fires[0], 5);
            check("reload_p2", fires[2] - fires[1], 5);
        end
        // Random ratio changes, including 0 and 1
        for (int k = 0; k < 300; k++) begin
            DIV_LOAD = ($urandom_range(0, 7) == 0);
            if (DIV_LOAD)
                for (int i = 0; i < NUM_CH; i++) DIV[i*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 9));
            tick();
        end
        DIV_LOAD = 1'b0;
        // Mid-RUN reset
        RST_N = 1'b0;
        tick();
        check("midrst_ready", READY, 0);
        check("midrst_ce", CE, 0);
        RST_N = 1'b1;
        // Lock glitch during SETTLE
        repeat (12) tick();
        LOCK = 1'b0;
        tick();
        LOCK = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!READY && n < 60);
        check("glitch_lat", n, 19);
        check("ratio_reset", CE, 4'b1111);
        check("glitch_loss", LOSS_CNT, 0);
        // Repeated lock loss in RUN with random hold times
        for (int k = 0; k < 300; k++) begin
            repeat ($urandom_range(0, 4)) tick();
            LOCK = 1'b0;
            n = 0;
            do begin tick(); n++; end while (READY && n < 10);
            check("loss_lat", (n <= 3) && !READY && (CE == '0), 1);
            LOCK = 1'b1;
            n = 0;
            do begin tick(); n++; end while (!READY && n < 40);
            check("relock", READY, 1);
        end
        check("loss_sat", LOSS_CNT, 255);
        check("loss_flag", LOCK_LOST, 1);
        // LOSS_CLR coinciding with LOST
        LOCK = 1'b0;
        n = 0;
        do begin tick(); n++; end while (READY && n < 10);
        LOSS_CLR = 1'b1;
        tick();
        LOSS_CLR = 1'b0;
        check("clr_vs_loss_cnt", LOSS_CNT, 1);
        check("clr_vs_loss_flag", LOCK_LOST, 1);
        tick();
        LOSS_CLR = 1'b1;
        tick();
        LOSS_CLR = 1'b0;
        check("clr_cnt", LOSS_CNT, 0);
        check("clr_flag", LOCK_LOST, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
